// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the memory-mapped UART transmitter
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    // STATUS word bit positions
    localparam int STAT_FULL    = 0;
    localparam int STAT_EMPTY   = 1;
    localparam int STAT_BUSY    = 2;
    localparam int STAT_OVF     = 3;
    localparam int STAT_CNT_LSB = 4;

    // Word offsets from BASE_ADDR
    localparam logic [9:0] REG_TXDATA = 10'd0;
    localparam logic [9:0] REG_STATUS = 10'd1;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock byte FIFO with full/empty/count flags
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   push, wdata      write request and data (ignored while full)
//   pop, rdata       read request (ignored while empty); rdata shows the head entry
//   full, empty      occupancy flags, derived from count
//   count            number of stored entries, $clog2(DEPTH)+1 bits
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    // Flags come from the pre-edge count, so a pop on the same edge never frees room for a push.
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Storage needs no reset: entries are only visible once count says so.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// rtl/mmio_uart_tx.sv - memory-mapped 8N1 UART transmitter with byte FIFO and STATUS word
//
// Ports:
//   clk, rst_n     clock shared with the CPU, asynchronous active-low reset
//   mem_write      CPU store strobe
//   data_addr      CPU data word address; BASE_ADDR = TXDATA, BASE_ADDR+1 = STATUS
//   data_in        CPU store data; [7:0] is the byte pushed, [3] on a STATUS store clears ovf
//   status_out     combinational STATUS word for the load-data mux
//   tx             registered serial line, idle high
//   busy           FIFO non-empty or a frame in progress
module mmio_uart_tx
    import uart_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 16,
    parameter int         FIFO_DEPTH   = 8,
    parameter logic [9:0] BASE_ADDR    = 10'h3F0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_write,
    input  logic [9:0]  data_addr,
    input  logic [31:0] data_in,
    output logic [31:0] status_out,
    output logic        tx,
    output logic        busy
);

    localparam int            BW          = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int            CW          = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BW-1:0] BAUD_LAST   = BW'(CLKS_PER_BIT - 1);
    localparam logic [9:0]    TXDATA_ADDR = BASE_ADDR + REG_TXDATA;
    localparam logic [9:0]    STATUS_ADDR = BASE_ADDR + REG_STATUS;

    tx_state_e     state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_d;
    logic          ovf_q;

    logic          push_req;
    logic          ovf_clear;
    logic          fifo_pop;
    logic [7:0]    fifo_rdata;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [3:0]    cnt_sat;
    logic          baud_done;
    logic          unused_data;

    assign push_req    = mem_write && (data_addr == TXDATA_ADDR);
    assign ovf_clear   = mem_write && (data_addr == STATUS_ADDR) && data_in[3];
    assign unused_data = ^data_in[31:8];

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_req),
        .wdata (data_in[7:0]),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (push_req && fifo_full) begin
            ovf_q <= 1'b1;
        end else if (ovf_clear) begin
            ovf_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx      <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx      <= tx_d;
        end
    end

    assign baud_done = (baud_q == BAUD_LAST);

    // tx is registered, so each branch presents the level for the state being entered.
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        tx_d     = tx;
        fifo_pop = 1'b0;
        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_rdata;
                    baud_d   = '0;
                    state_d  = ST_START;
                    tx_d     = 1'b0;
                end
            end
            ST_START: begin
                if (baud_done) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = ST_DATA;
                    tx_d    = shift_q[0];
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (baud_done) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        tx_d = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            ST_STOP: begin
                if (baud_done) begin
                    baud_d = '0;
                    // Chain straight into the next start bit when more data is waiting.
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_rdata;
                        state_d  = ST_START;
                        tx_d     = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                        tx_d    = 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    assign busy = !fifo_empty || (state_q != ST_IDLE);

    always_comb begin
        cnt_sat = 4'(fifo_count);
        if (32'(fifo_count) > 32'd15) begin
            cnt_sat = 4'hF;
        end
    end

    always_comb begin
        status_out                               = '0;
        status_out[STAT_FULL]                    = fifo_full;
        status_out[STAT_EMPTY]                   = fifo_empty;
        status_out[STAT_BUSY]                    = (state_q != ST_IDLE);
        status_out[STAT_OVF]                     = ovf_q;
        status_out[STAT_CNT_LSB+3:STAT_CNT_LSB]  = cnt_sat;
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb/tb_mmio_uart_tx.sv - self-checking bench for mmio_uart_tx against a frame-level line model
module tb_mmio_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_write = 1'b0;
    logic [9:0]  data_addr = '0;
    logic [31:0] data_in = '0;
    logic [31:0] status_out;
    logic        tx;
    logic        busy;

    int checks = 0;
    int passed = 0;

    logic       rec = 1'b0;
    logic       cap[$];
    logic [7:0] exp_bytes[$];

    mmio_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH),
        .BASE_ADDR    (10'h3F0)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem_write  (mem_write),
        .data_addr  (data_addr),
        .data_in    (data_in),
        .status_out (status_out),
        .tx         (tx),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Line recorder: one sample per clock cycle, taken mid-cycle.
    always @(negedge clk) begin
        if (rec) cap.push_back(tx);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // 8N1 frame, one entry per clock cycle: start low, data LSB first, stop high.
    function automatic logic [FRAME-1:0] frame_bits(input logic [7:0] b);
        logic [FRAME-1:0] f;
        for (int i = 0; i < FRAME; i++) begin
            if (i < CPB)            f[i] = 1'b0;
            else if (i < 9 * CPB)   f[i] = b[(i - CPB) / CPB];
            else                    f[i] = 1'b1;
        end
        return f;
    endfunction

    // Compare the recorded line: 'lead' idle cycles, exp_bytes frames back to back, then idle.
    task automatic check_stream(input string tag, input int lead);
        logic [FRAME-1:0] a;
        int ones;
        int n;
        n = exp_bytes.size();
        ones = 0;
        for (int i = 0; i < lead; i++) ones += (cap.size() > i && cap[i] === 1'b1) ? 1 : 0;
        check({tag, "_lead"}, ones, lead);
        for (int f = 0; f < n; f++) begin
            for (int i = 0; i < FRAME; i++) begin
                int idx = lead + f * FRAME + i;
                a[i] = (idx < cap.size()) ? cap[idx] : 1'bx;
            end
            check($sformatf("%s_frame%0d", tag, f), 64'(a), 64'(frame_bits(exp_bytes[f])));
        end
        ones = 0;
        for (int i = 0; i < CPB; i++) begin
            int idx = lead + n * FRAME + i;
            ones += (idx < cap.size() && cap[idx] === 1'b1) ? 1 : 0;
        end
        check({tag, "_tail_idle"}, ones, CPB);
    endtask

    // Consecutive-cycle stores of exp_bytes, with random junk in the ignored upper bits.
    task automatic run_burst(input string tag);
        cap.delete();
        rec = 1'b1;
        foreach (exp_bytes[i]) begin
            mem_write = 1'b1;
            data_addr = 10'h3F0;
            data_in   = {$urandom_range(0, 32'hFF_FFFF) , exp_bytes[i]};
            tick();
        end
        mem_write = 1'b0;
        repeat (2 + FRAME * exp_bytes.size() + CPB + 2) tick();
        rec = 1'b0;
        check_stream(tag, 2);
        check({tag, "_busy_end"}, busy, 1'b0);
    endtask

    initial begin
        int zeros;
        int n;

        // Reset
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx", tx, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_status", status_out, 32'h2);
        rst_n = 1'b1;
        tick();
        check("post_rst_status", status_out, 32'h2);

        // Single byte
        cap.delete();
        rec = 1'b1;
        mem_write = 1'b1;
        data_addr = 10'h3F0;
        data_in   = 32'hABCD_0055;
        tick();
        mem_write = 1'b0;
        check("single_status_push", status_out, 32'h10);
        check("single_tx_before_pop", tx, 1'b1);
        tick();
        check("single_tx_start", tx, 1'b0);
        repeat (FRAME - 1) tick();
        check("single_busy_last_stop", busy, 1'b1);
        tick();
        check("single_busy_drop", busy, 1'b0);
        check("single_status_idle", status_out, 32'h2);
        repeat (6) tick();
        rec = 1'b0;
        exp_bytes = '{8'h55};
        check_stream("single", 2);

        // Back-to-back directed
        exp_bytes = '{8'h01, 8'h02, 8'h03};
        run_burst("b2b");

        // Randomized bursts, never deeper than FIFO plus shift register
        for (int r = 0; r < 3; r++) begin
            exp_bytes.delete();
            n = $urandom_range(1, DEPTH + 1);
            for (int i = 0; i < n; i++) exp_bytes.push_back(8'($urandom));
            run_burst($sformatf("rand%0d", r));
        end

        // Overflow: six stores from idle, the sixth is dropped
        exp_bytes.delete();
        for (int i = 0; i < 6; i++) exp_bytes.push_back(8'($urandom));
        cap.delete();
        rec = 1'b1;
        foreach (exp_bytes[i]) begin
            mem_write = 1'b1;
            data_addr = 10'h3F0;
            data_in   = {24'h0, exp_bytes[i]};
            tick();
        end
        mem_write = 1'b0;
        check("ovf_status", status_out, 32'h4D);
        mem_write = 1'b1;
        data_addr = 10'h3F1;
        data_in   = 32'h8;
        tick();
        mem_write = 1'b0;
        check("ovf_clear_status", status_out, 32'h45);
        void'(exp_bytes.pop_back());
        repeat (2 + FRAME * 5 + CPB) tick();
        rec = 1'b0;
        check_stream("ovf", 2);

        // Reset mid-frame during data bit 3
        foreach (exp_bytes[i]) exp_bytes[i] = 8'h00;
        for (int i = 0; i < 3; i++) begin
            mem_write = 1'b1;
            data_addr = 10'h3F0;
            data_in   = 32'h0000_0000 | (i == 0 ? 32'h0 : 32'hF0);
            tick();
        end
        mem_write = 1'b0;
        repeat (15) tick();
        check("midrst_tx_bit3_low", tx, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_tx_async", tx, 1'b1);
        check("midrst_busy", busy, 1'b0);
        check("midrst_status", status_out, 32'h2);
        tick();
        rst_n = 1'b1;
        cap.delete();
        rec = 1'b1;
        repeat (50) tick();
        rec = 1'b0;
        zeros = 0;
        foreach (cap[i]) zeros += (cap[i] !== 1'b1) ? 1 : 0;
        check("midrst_no_residual", zeros, 0);
        check("midrst_count", status_out[7:4], 4'h0);

        // Decode isolation
        cap.delete();
        rec = 1'b1;
        mem_write = 1'b1;
        data_addr = 10'h3EF;
        data_in   = 32'h55;
        tick();
        data_addr = 10'h3F2;
        tick();
        mem_write = 1'b0;
        data_addr = 10'h3F0;
        tick();
        check("decode_status", status_out, 32'h2);
        repeat (20) tick();
        rec = 1'b0;
        zeros = 0;
        foreach (cap[i]) zeros += (cap[i] !== 1'b1) ? 1 : 0;
        check("decode_tx_idle", zeros, 0);
        check("decode_busy", busy, 1'b0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
